// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
//
// Definitions shared by the instruction-memory loader (write side) and the
// instruction-memory read side.
//
// Contents:
//   IMEM_ADDR_W  byte-address width of the instruction memory
//   IMEM_BYTES   instruction memory size in bytes
//   loader_st_e  loader FSM state encoding
//   csum_step    running XOR update used for the frame checksum
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int IMEM_BYTES  = 1 << IMEM_ADDR_W;

  typedef enum logic [2:0] {
    LOADER_ST_IDLE,
    LOADER_ST_LEN_LO,
    LOADER_ST_LEN_HI,
    LOADER_ST_DATA,
    LOADER_ST_CSUM,
    LOADER_ST_DONE,
    LOADER_ST_ERROR
  } loader_st_e;

  // The checksum is a plain XOR over every frame byte before CSUM.
  function automatic logic [7:0] csum_step(input logic [7:0] acc,
                                           input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage : imem_pkg

// File: rtl/imem_loader_wport.sv
// -----------------------------------------------------------------------------
// imem_loader_wport
//
// Registered byte write port towards the instruction memory, plus the byte
// counter that generates the write address. A byte presented on wr_en appears
// on mem_we/mem_addr/mem_wdata one cycle later.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high; drops mem_we on the same edge
//   clear      restart the byte counter at 0 (start of the data phase)
//   wr_en      write wr_data at BASE_ADDR + byte_cnt, then advance byte_cnt
//   wr_data    byte to write
//   byte_cnt   index of the next data byte within the current frame
//   mem_we     byte write strobe (one cycle per written byte)
//   mem_addr   byte address of the write
//   mem_wdata  byte to write
// -----------------------------------------------------------------------------
module imem_loader_wport
  import imem_pkg::*;
#(
  parameter int                ADDR_W    = IMEM_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] byte_cnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata
);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
    end else begin
      // The strobe is re-evaluated every cycle, so it is high for exactly one
      // cycle per accepted byte; address and data simply hold between writes.
      mem_we <= wr_en;
      if (clear) begin
        byte_cnt <= '0;
      end else if (wr_en) begin
        byte_cnt  <= byte_cnt + ADDR_W'(1);
        // Addition wraps naturally at 2^ADDR_W.
        mem_addr  <= BASE_ADDR + byte_cnt;
        mem_wdata <= wr_data;
      end
    end
  end

endmodule : imem_loader_wport

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writer side of the instruction memory. Receives a framed byte stream
//   LEN_LO, LEN_HI, 4*LEN data bytes (LSB of each word first), CSUM
// over a valid/ready handshake, writes the data bytes to consecutive byte
// addresses starting at BASE_ADDR, holds the core in reset while loading and
// reports success (load_done) or a length/checksum failure (load_error).
//
// Ports:
//   clk           clock, rising edge
//   reset         synchronous, active-high
//   start         one-cycle pulse; begins a load from IDLE, DONE or ERROR
//   in_valid      in_data holds a byte
//   in_data       stream byte
//   in_ready      loader accepts a byte this cycle
//   mem_we        byte write strobe to the instruction memory
//   mem_addr      byte address of the write
//   mem_wdata     byte to write
//   cpu_hold      keeps the core in reset
//   load_done     level; load complete and checksum good
//   load_error    level; length or checksum error
//   words_loaded  complete 32-bit words written in the current load
// -----------------------------------------------------------------------------
module imem_loader
  import imem_pkg::*;
#(
  parameter int                ADDR_W    = IMEM_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [8:0]        words_loaded
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  loader_st_e        state;
  logic [7:0]        len_lo;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] last_idx;   // index of the final data byte (4*len-1)
  logic [ADDR_W-1:0] byte_cnt;
  logic [15:0]       len_val;
  logic              accept;
  logic              wr_en;
  logic              cnt_clear;

  // in_ready is only ever high in the four receiving states, so a transfer
  // can never happen in IDLE/DONE/ERROR.
  assign accept    = in_valid && in_ready;
  assign len_val   = {in_data, len_lo};
  assign wr_en     = accept && (state == LOADER_ST_DATA);
  assign cnt_clear = accept && (state == LOADER_ST_LEN_HI);

  imem_loader_wport #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_wport (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clear),
    .wr_en     (wr_en),
    .wr_data   (in_data),
    .byte_cnt  (byte_cnt),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  // Every output flag is registered and updated on the transition that
  // enters the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LOADER_ST_IDLE;
      in_ready     <= 1'b0;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
      csum         <= '0;
      len_lo       <= '0;
      last_idx     <= '0;
    end else begin
      case (state)
        // start is only honoured when no load is in progress.
        LOADER_ST_IDLE, LOADER_ST_DONE, LOADER_ST_ERROR: begin
          if (start) begin
            state        <= LOADER_ST_LEN_LO;
            in_ready     <= 1'b1;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            csum         <= '0;
          end
        end

        LOADER_ST_LEN_LO: begin
          if (accept) begin
            len_lo <= in_data;
            csum   <= csum_step(csum, in_data);
            state  <= LOADER_ST_LEN_HI;
          end
        end

        LOADER_ST_LEN_HI: begin
          if (accept) begin
            csum <= csum_step(csum, in_data);
            if (len_val > MAX_LEN) begin
              state      <= LOADER_ST_ERROR;
              in_ready   <= 1'b0;
              load_error <= 1'b1;
            end else if (len_val == 16'd0) begin
              state <= LOADER_ST_CSUM;
            end else begin
              state    <= LOADER_ST_DATA;
              // len <= MAX_WORDS guarantees 4*len-1 fits in ADDR_W bits.
              last_idx <= ADDR_W'({len_val, 2'b00} - 18'd1);
            end
          end
        end

        LOADER_ST_DATA: begin
          if (accept) begin
            csum <= csum_step(csum, in_data);
            // Fourth byte of a word completes it.
            if (byte_cnt[1:0] == 2'b11) begin
              words_loaded <= words_loaded + 9'd1;
            end
            if (byte_cnt == last_idx) begin
              state <= LOADER_ST_CSUM;
            end
          end
        end

        LOADER_ST_CSUM: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state     <= LOADER_ST_DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state      <= LOADER_ST_ERROR;
              load_error <= 1'b1;
            end
          end
        end

        default: begin
          state    <= LOADER_ST_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader. A monitor logs every memory write; each
// scenario streams a frame and compares outputs and the write log against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;
  logic [8:0]        words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  // Write log filled by the monitor.
  logic [ADDR_W-1:0] log_addr [256];
  logic [7:0]        log_data [256];
  int                wr_total = 0;

  // Data bytes of the nominal program (two words: 0x00400293, 0x00900313).
  logic [7:0] nom [8] = '{8'h93, 8'h02, 8'h40, 8'h00, 8'h13, 8'h03, 8'h90, 8'h00};

  imem_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      if (wr_total < 256) begin
        log_addr[wr_total] <= mem_addr;
        log_data[wr_total] <= mem_wdata;
      end
      wr_total <= wr_total + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte and hold it until accepted; optional idle cycle first.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int waited;
    if (gap) begin
      in_valid = 1'b0;
      tick();
      check("gap_no_write", mem_we, 1'b0);
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 16) begin
      tick();
      waited++;
    end
    if (waited >= 16) check("ready_timeout", in_ready, 1'b1);
    tick();
  endtask

  task automatic send_frame(input logic [7:0] csum_byte, input bit gap);
    send_byte(8'h02, gap);
    send_byte(8'h00, gap);
    for (int k = 0; k < 8; k++) send_byte(nom[k], gap);
    send_byte(csum_byte, gap);
    in_valid = 1'b0;
  endtask

  // Write log since 'base' must be addresses 0..7 carrying the nominal image.
  task automatic check_image(input int base);
    logic [31:0] w0;
    logic [31:0] w1;
    logic        addr_ok;
    addr_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (log_addr[base + k] !== ADDR_W'(k)) addr_ok = 1'b0;
    end
    w0 = {log_data[base + 3], log_data[base + 2], log_data[base + 1], log_data[base]};
    w1 = {log_data[base + 7], log_data[base + 6], log_data[base + 5], log_data[base + 4]};
    check("write_count", wr_total - base, 8);
    check("write_addrs", addr_ok, 1'b1);
    check("word_at_0", w0, 32'h0040_0293);
    check("word_at_4", w1, 32'h0090_0313);
  endtask

  initial begin
    int base;

    // ---------------- reset state
    tick();
    tick();
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 10'h000);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    check("rst_cpu_hold", cpu_hold, 1'b0);
    check("rst_done", load_done, 1'b0);
    check("rst_error", load_error, 1'b0);
    check("rst_words", words_loaded, 9'd0);
    tick();
    check("idle_in_ready", in_ready, 1'b0);

    // ---------------- nominal load
    base = wr_total;
    pulse_start();
    check("nom_in_ready", in_ready, 1'b1);
    check("nom_cpu_hold", cpu_hold, 1'b1);
    in_valid = 1'b1;
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    check("nom_no_write_len", mem_we, 1'b0);
    send_byte(8'h93, 1'b0);
    check("nom_lat_we", mem_we, 1'b1);
    check("nom_lat_addr", mem_addr, 10'h000);
    check("nom_lat_data", mem_wdata, 8'h93);
    for (int k = 1; k < 8; k++) send_byte(nom[k], 1'b0);
    check("nom_words", words_loaded, 9'd2);
    send_byte(8'h53, 1'b0);
    in_valid = 1'b0;
    check("nom_done", load_done, 1'b1);
    check("nom_error", load_error, 1'b0);
    check("nom_cpu_hold_rel", cpu_hold, 1'b0);
    check("nom_ready_low", in_ready, 1'b0);
    check_image(base);

    // ---------------- backpressure (restart from DONE)
    base = wr_total;
    pulse_start();
    check("bp_done_cleared", load_done, 1'b0);
    check("bp_words_cleared", words_loaded, 9'd0);
    check("bp_cpu_hold", cpu_hold, 1'b1);
    send_frame(8'h53, 1'b1);
    check("bp_done", load_done, 1'b1);
    check("bp_words", words_loaded, 9'd2);
    check("bp_cpu_hold_rel", cpu_hold, 1'b0);
    check_image(base);

    // ---------------- oversize length 0x0101 = 257 words
    base = wr_total;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    in_valid = 1'b0;
    check("ovs_error", load_error, 1'b1);
    check("ovs_done", load_done, 1'b0);
    check("ovs_cpu_hold", cpu_hold, 1'b1);
    check("ovs_in_ready", in_ready, 1'b0);
    tick();
    tick();
    check("ovs_no_writes", wr_total - base, 0);

    // ---------------- bad checksum (restart from ERROR)
    base = wr_total;
    pulse_start();
    check("bcs_error_cleared", load_error, 1'b0);
    check("bcs_in_ready", in_ready, 1'b1);
    send_frame(8'h54, 1'b0);
    check("bcs_error", load_error, 1'b1);
    check("bcs_done", load_done, 1'b0);
    check("bcs_words", words_loaded, 9'd2);
    check("bcs_cpu_hold", cpu_hold, 1'b1);
    check_image(base);

    // ---------------- zero length, then a nominal load
    base = wr_total;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    in_valid = 1'b0;
    tick();
    check("zero_done", load_done, 1'b1);
    check("zero_error", load_error, 1'b0);
    check("zero_words", words_loaded, 9'd0);
    check("zero_no_writes", wr_total - base, 0);
    base = wr_total;
    pulse_start();
    check("zero2_done_cleared", load_done, 1'b0);
    send_frame(8'h53, 1'b0);
    check("zero2_done", load_done, 1'b1);
    check("zero2_words", words_loaded, 9'd2);
    check_image(base);

    // ---------------- reset in the middle of the data phase
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int k = 0; k < 5; k++) send_byte(nom[k], 1'b0);
    check("mid_we_pending", mem_we, 1'b1);
    check("mid_addr_pending", mem_addr, 10'h004);
    check("mid_words", words_loaded, 9'd1);
    in_data = nom[5];
    reset   = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_we", mem_we, 1'b0);
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_cpu_hold", cpu_hold, 1'b0);
    check("mid_rst_words", words_loaded, 9'd0);
    base = wr_total;
    tick();
    tick();
    check("mid_rst_no_writes", wr_total - base, 0);
    base = wr_total;
    pulse_start();
    check("mid_restart_ready", in_ready, 1'b1);
    send_frame(8'h53, 1'b0);
    check("mid_restart_done", load_done, 1'b1);
    check_image(base);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_imem_loader
